// File: rtl/cla_pkg.sv
// Shared definitions for the multi-precision CLA sequencer.
//   SLICE_W  : width of one adder slice
//   state_e  : sequencer states
//   slice_lo : low bit of slice i inside a packed multi-word operand
package cla_pkg;
  localparam int SLICE_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned slice_lo(input int unsigned i);
    return i * SLICE_W;
  endfunction
endpackage

// File: rtl/cla_mp_add_seq_if.sv
// Host-side bus of the multi-precision add/subtract sequencer.
//   master : host (drives start/op_sub/operands, sees status/result)
//   slave  : sequencer
interface cla_mp_add_seq_if #(parameter int WORDS = 4);
  localparam int DW = 16 * WORDS;

  logic          start;
  logic          op_sub;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic          cin_in;
  logic          busy;
  logic          done;
  logic [DW-1:0] sum_out;
  logic          cout_out;
  logic          overflow;

  modport master (
    output start, op_sub, a_in, b_in, cin_in,
    input  busy, done, sum_out, cout_out, overflow
  );

  modport slave (
    input  start, op_sub, a_in, b_in, cin_in,
    output busy, done, sum_out, cout_out, overflow
  );
endinterface

// File: rtl/bit16_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups, group generate/propagate
// resolve the inter-group carries, bits inside a group ripple from the group carry.
//   ain, bin : addends
//   cin      : carry in
//   sum      : ain + bin + cin (low 16 bits)
//   cout     : carry out of bit 15
module bit16_cla (
  input  logic [15:0] ain,
  input  logic [15:0] bin,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g, p;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;
  logic [16:0] c;

  assign g = ain & bin;
  assign p = ain ^ bin;

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
    gc[0] = cin;
    for (int i = 0; i < 4; i++) gc[i+1] = gg[i] | (gp[i] & gc[i]);
    for (int b = 0; b < 16; b++) begin
      if (b % 4 == 0) c[b] = gc[b/4];
      else            c[b] = g[b-1] | (p[b-1] & c[b-1]);
    end
    c[16] = gc[4];
  end

  assign sum  = p ^ c[15:0];
  assign cout = c[16];
endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision add/subtract sequencer: one shared 16-bit CLA walks the
// operands LSW first, one slice per clock, carry chained through a register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/op_sub/a_in/b_in/cin_in in; busy/done/sum_out/cout_out/overflow out
module cla_mp_add_seq
  import cla_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  cla_mp_add_seq_if.slave bus
);
  localparam int DW = SLICE_W * WORDS;
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  logic [0:0]         state;
  logic [IDXW-1:0]    idx, sel;
  logic               carry;
  logic [DW-1:0]      a_q, b_q, sum_q;
  logic               busy_q, done_q, cout_q, ovf_q;
  logic [SLICE_W-1:0] cla_a, cla_b, cla_s;
  logic               cla_co;

  // Idle still reads a real registered slice so nothing floats into the adder.
  assign sel   = (state == ST_RUN) ? idx : '0;
  assign cla_a = a_q[slice_lo(32'(sel)) +: SLICE_W];
  assign cla_b = b_q[slice_lo(32'(sel)) +: SLICE_W];

  bit16_cla u_cla (
    .ain  (cla_a),
    .bin  (cla_b),
    .cin  (carry),
    .sum  (cla_s),
    .cout (cla_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.start) begin
          // Subtract is A + ~B + 1: invert B once here, seed carry with 1.
          a_q    <= bus.a_in;
          b_q    <= bus.op_sub ? ~bus.b_in : bus.b_in;
          carry  <= bus.op_sub ? 1'b1 : bus.cin_in;
          idx    <= '0;
          state  <= ST_RUN;
          busy_q <= 1'b1;
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end
        ST_RUN: begin
          sum_q[slice_lo(32'(idx)) +: SLICE_W] <= cla_s;
          carry <= cla_co;
          idx   <= idx + IDXW'(1);
          if (idx == LAST) begin
            cout_q <= cla_co;
            // b_q already holds the effective (possibly inverted) B.
            ovf_q  <= (a_q[DW-1] == b_q[DW-1]) && (cla_s[SLICE_W-1] != a_q[DW-1]);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            idx    <= '0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum_out  = sum_q;
  assign bus.cout_out = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Directed bench for cla_mp_add_seq with WORDS=4 (64-bit operands).
module tb_cla_mp_add_seq;
  localparam int W  = 4;
  localparam int DW = 16 * W;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  cla_mp_add_seq_if #(.WORDS(W)) bus ();

  cla_mp_add_seq #(.WORDS(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request; the caller positions this in the cycle it should be sampled.
  task automatic launch(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic sub, input logic cin);
    bus.start  = 1'b1;
    bus.a_in   = a;
    bus.b_in   = b;
    bus.op_sub = sub;
    bus.cin_in = cin;
  endtask

  // Called right after launch(); follows the busy window and checks the result
  // in the done cycle. poke=1 raises start during RUN with junk operands.
  task automatic finish_op(input string tag, input bit poke, input logic [DW-1:0] es,
                           input logic ec, input logic eo);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      bus.start  = (poke && i == 1);
      bus.a_in   = {$urandom, $urandom};
      bus.b_in   = {$urandom, $urandom};
      bus.op_sub = 1'($urandom);
      bus.cin_in = 1'($urandom);
      chk({tag, "_busy"}, DW'({bus.busy, bus.done}), DW'(2'b10));
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done"}, DW'({bus.busy, bus.done}), DW'(2'b01));
    chk({tag, "_sum"},  bus.sum_out, es);
    chk({tag, "_cout"}, DW'(bus.cout_out), DW'(ec));
    chk({tag, "_ovf"},  DW'(bus.overflow), DW'(eo));
  endtask

  // From a done cycle: step one cycle, confirm done was a single pulse.
  task automatic gap(input string tag);
    @(negedge clk);
    chk({tag, "_gap"}, DW'({bus.busy, bus.done}), DW'(2'b00));
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1;
    launch(64'h1234, 64'h5678, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {bus.sum_out[DW-1:4], bus.busy, bus.done, bus.cout_out, bus.overflow}, '0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("reset_idle", DW'({bus.busy, bus.done}), DW'(2'b00));

    launch(64'h7FFF, 64'h8000, 1'b0, 1'b0);
    finish_op("add", 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0);
    gap("add");

    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1);
    finish_op("ripple", 1'b0, 64'h0, 1'b1, 1'b0);
    gap("ripple");

    launch(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    finish_op("sovf", 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    gap("sovf");

    launch(64'd8, 64'd9, 1'b1, 1'b1);
    finish_op("sub89", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    gap("sub89");

    launch(64'd9, 64'd8, 1'b1, 1'b1);
    finish_op("sub98", 1'b0, 64'h1, 1'b1, 1'b0);
    gap("sub98");

    // start pulsed mid-run must not disturb the result
    launch(64'h7FFF, 64'h8000, 1'b0, 1'b0);
    finish_op("poke", 1'b1, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0);

    // start held in the done cycle: busy next cycle, no bubble
    launch(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
    finish_op("b2b", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    gap("b2b");

    // abort: rst sampled at the end of the 2nd RUN cycle
    launch(64'h1111, 64'h2222, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_run1", DW'(bus.busy), DW'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", {bus.sum_out[DW-1:4], bus.busy, bus.done, bus.cout_out, bus.overflow}, '0);
    chk("abort_sumlo", DW'(bus.sum_out[3:0]), '0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("abort_quiet", DW'(seen_done), DW'(1'b0));

    launch(64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    finish_op("recover", 1'b0, 64'h0002_0000_0000_0000, 1'b0, 1'b0);
    gap("recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_mp_add_seq.md
Name: cla_mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around one shared bit16_cla (16-bit carry-lookahead adder: ain, bin, cin -> sum, cout).
- Processes a WORDS×16-bit operand pair one 16-bit slice per clock, LSW first, chaining the carry through a register.
- Presents a start/busy/done handshake to the host. Sits between control logic (for example an LFSR-driven test engine) and the adder datapath.

Parameters:
- WORDS, 4, number of 16-bit slices (operand width = 16*WORDS); legal range 1..16.
- IDXW, $clog2(WORDS) with minimum 1, width of the slice index counter (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a new operation; sampled only while idle.
- op_sub  in  1  0 = A+B+cin_in; 1 = A-B, computed as A+~B+1 (cin_in ignored).
- a_in  in  16*WORDS  operand A; captured on the accepted start edge.
- b_in  in  16*WORDS  operand B; captured on the accepted start edge.
- cin_in  in  1  carry-in for add; captured on the accepted start edge.
- busy  out  1  high while slices are being processed.
- done  out  1  single-cycle pulse; results are valid from this cycle on.
- sum_out  out  16*WORDS  result; held until the next accepted start.
- cout_out  out  1  final carry-out; for subtract, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow of the full-width result.

Behaviour:
- States: IDLE, RUN. Carry and operands are registered; the adder is fed combinationally from the registered slice selected by idx.
- Reset, applied synchronously on any edge with rst=1, sets:
  - state=IDLE, idx=0, carry=0;
  - busy=0, done=0, sum_out=0, cout_out=0, overflow=0;
  - operand registers to 0.
- IDLE with start=1 (edge k):
  - latch a_in into A;
  - latch b_in into B, or ~b_in when op_sub=1;
  - carry <= op_sub ? 1 : cin_in;
  - idx <= 0, state <= RUN, busy <= 1;
  - clear sum_out, cout_out and overflow.
- RUN, each edge:
  - sum_out slice[idx] <= cla.sum;
  - carry <= cla.cout;
  - idx <= idx+1.
- The cla inputs in RUN are: ain = A slice[idx], bin = B slice[idx], cin = carry.
- Last slice (idx==WORDS-1), edge k+WORDS:
  - write the slice;
  - cout_out <= cla.cout;
  - overflow <= (A msb == Beff msb) && (cla.sum msb != A msb), where Beff is the inverted B for subtract;
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: busy is high for exactly WORDS cycles; done is high in the cycle following edge k+WORDS, for exactly one cycle.
- start while busy is ignored (not queued). start=1 in the done cycle is accepted, giving back-to-back operation with no bubble beyond the done cycle.
- Inputs a_in, b_in, op_sub and cin_in may change freely after the start edge without affecting the running operation.
- WORDS=1: single RUN cycle; done follows the start edge by 1 cycle of busy.
- rst during RUN aborts the operation: the next cycle shows idle, done never pulses, and all outputs are zero.
- cla inputs in IDLE are driven from the registered slice 0 (don't-care functionally; no X propagation).

Decomposition:
- Shared package cla_pkg:
  - SLICE_W=16 constant;
  - state enum {IDLE, RUN};
  - helper function for the slice-select index range.
- One sub-module instance: bit16_cla u_cla (existing block, unmodified).
- All sequencing lives in cla_mp_add_seq. No further hierarchy.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> busy=0, done=0, sum_out=0, cout_out=0, overflow=0, no operation started.
- Add, no carry (WORDS=4): A=0x7FFF, B=0x8000, cin=0 -> busy 4 cycles, then done pulse, sum=0x000000000000FFFF, cout=0, overflow=0.
- Full ripple: A=0xFFFFFFFFFFFFFFFF, B=0, cin=1 -> sum=0, cout=1, overflow=0.
- Signed overflow: A=0x7FFFFFFFFFFFFFFF, B=1, cin=0 -> sum=0x8000000000000000, cout=0, overflow=1.
- Subtract:
  - A=8, B=9 -> sum=0xFFFFFFFFFFFFFFFF, cout=0, overflow=0;
  - A=9, B=8 -> sum=1, cout=1;
  - cin_in=1 in both cases, with no effect.
- Handshake and abort:
  - start pulsed during RUN -> ignored, result unchanged;
  - start held high in the done cycle -> second operation starts immediately, with busy high the next cycle;
  - rst asserted on the 2nd RUN cycle -> idle the next cycle, no done pulse, sum_out=0.
